wb_ram_responder: RTL
=====================

# wb_ram_responder

Wishbone classic responder: the target end of the Sentinel core's instruction/data bus. Backs the core's 30-bit word-addressed, 32-bit, byte-selectable bus with an on-chip RAM. Inserts a configurable number of wait states plus externally injected stalls, with a hard cap on latency. Used in simulation and formal harnesses as a well-behaved memory, and on FPGA as boot/scratch RAM.

## Interface
- DEPTH_WORDS, 1024: RAM size in 32-bit words; power of two, 16..65536.
- WAIT_STATES, 1: minimum wait cycles before ack; legal 1..6.
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- bus__cyc  in  1  bus cycle in progress.
- bus__stb  in  1  strobe, request valid.
- bus__we  in  1  1 = write, 0 = read.
- bus__adr  in  30  word address.
- bus__sel  in  4  byte lane enables; bit n covers dat bits 8n+7:8n.
- bus__dat_w  in  32  write data.
- bus__dat_r  out  32  read data, valid only while bus__ack = 1, else 0.
- bus__ack  out  1  transfer acknowledge, registered, one-cycle pulse.
- stall_i  in  1  injects extra wait states (test/fairness hook).

## Operation
- FSM states: IDLE, WAIT, ACK. Reset: state IDLE, cnt 0, bus__ack 0, bus__dat_r 0, latched request cleared. RAM contents are not reset.
- IDLE: if bus__cyc & bus__stb, latch adr/we/sel/dat_w, cnt <= 1, go WAIT. Bus changes after this latch are ignored until the next accept.
- WAIT:
  - If !bus__cyc: abort. Go IDLE, no ack, no write.
  - Else if cnt >= WAIT_STATES and (!stall_i or cnt == 6): go ACK.
  - Else cnt <= cnt + 1 (3-bit, never exceeds 6).
- ACK: bus__ack = 1 for exactly this cycle; unconditionally go IDLE.
  - Read: bus__dat_r = RAM[adr] for the full word; sel is ignored for reads.
  - Write: at the edge ending the ACK cycle, and only if bus__cyc = 1, update each lane whose sel bit = 1. bus__dat_r = 0.
- Out of range (adr >= DEPTH_WORDS): still acked; reads return 0, writes are dropped.
- sel = 0000 on a write: acked, RAM unchanged.

## Timing
- Request sampled in cycle t (state IDLE). WAIT occupies t+1 onward.
- bus__ack is high in cycle t+1+WAIT_STATES with no stall. With stall held, ack is latest in cycle t+7.
- Never acks in the first cycle a request is visible. Never acks two consecutive cycles.
- Back-to-back: the cycle after ACK is IDLE, so a held stb is re-accepted there. Minimum transfer period is WAIT_STATES+2 cycles.
- Cycles with cyc & !ack per transfer are at most 7. This satisfies the core's fairness bound (< 8).
- rst_n low mid-transfer: immediately IDLE with ack 0 and dat_r 0. A write not yet committed is lost.

## Structure
- Shared package sentinel_wb_pkg holds:
  - state enum wb_resp_state_t {IDLE, WAIT, ACK};
  - constants WB_ADR_W = 30, WB_DAT_W = 32, WB_SEL_W = 4;
  - WB_MAX_LAT = 7.
- Sub-module wb_resp_mem: byte-lane-write, synchronous-read RAM. Ports: clk, we, sel, addr, wdata, rdata. No reset.
- The read is issued from the last WAIT cycle so rdata is ready in ACK.
- The responder holds the FSM, counter, request latch and range check.

## Test plan
- Write adr 0x10, dat 0xDEADBEEF, sel 1111, WAIT_STATES=1; then read 0x10. Ack in t+2 for each; read returns 0xDEADBEEF.
- Write sel 0101, dat 0x11223344 over 0xDEADBEEF; read. Returns 0xDE22BE44.
- WAIT_STATES=3, stall_i held high during a read. Ack exactly in t+7, not before, one cycle only.
- Drop cyc in t+2 of a write to 0x20 (previously 0). No ack; subsequent read of 0x20 returns 0.
- Read adr 0x3FFFFFFF with DEPTH_WORDS=1024. Acked, dat_r = 0; write to the same address leaves all RAM unchanged.
- Assert rst_n low during WAIT. Same cycle ack = 0, dat_r = 0; after release, a new request is acked normally with prior RAM contents intact.

Source files
------------

// File: rtl/sentinel_wb_pkg.sv
// Shared Wishbone definitions for the Sentinel core bus and its responders.
package sentinel_wb_pkg;

    localparam int WB_ADR_W   = 30;
    localparam int WB_DAT_W   = 32;
    localparam int WB_SEL_W   = 4;
    // Worst-case cycles with cyc high and no ack for one transfer.
    localparam int WB_MAX_LAT = 7;
    // Wait counter ceiling: stalls cannot push the ack past WB_MAX_LAT.
    localparam logic [2:0] WB_CNT_MAX = 3'(WB_MAX_LAT - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK
    } wb_resp_state_t;

    // Request captured at accept time; the bus is ignored afterwards.
    typedef struct packed {
        logic                we;
        logic [WB_ADR_W-1:0] adr;
        logic [WB_SEL_W-1:0] sel;
        logic [WB_DAT_W-1:0] dat;
    } wb_req_t;

endpackage

// File: rtl/wb_resp_mem.sv
// Byte-lane-write, synchronous-read RAM behind the Wishbone responder.
module wb_resp_mem
    import sentinel_wb_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                we,
    input  logic [WB_SEL_W-1:0] sel,
    input  logic [AW-1:0]       addr,
    input  logic [WB_DAT_W-1:0] wdata,
    output logic [WB_DAT_W-1:0] rdata
);

    logic [WB_DAT_W-1:0] mem [DEPTH];

    // Per-lane write and registered read of the addressed word; no reset on contents.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < WB_SEL_W; i++) begin
                if (sel[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/wb_ram_responder.sv
// Wishbone classic responder backed by on-chip RAM, with programmable wait
// states, externally injected stalls and a hard latency ceiling.
module wb_ram_responder
    import sentinel_wb_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                bus__cyc,
    input  logic                bus__stb,
    input  logic                bus__we,
    input  logic [WB_ADR_W-1:0] bus__adr,
    input  logic [WB_SEL_W-1:0] bus__sel,
    input  logic [WB_DAT_W-1:0] bus__dat_w,
    output logic [WB_DAT_W-1:0] bus__dat_r,
    output logic                bus__ack,
    input  logic                stall_i
);

    localparam int         AW = $clog2(DEPTH_WORDS);
    localparam logic [2:0] WS = 3'(WAIT_STATES);

    wb_resp_state_t      state;
    logic [2:0]          cnt;
    wb_req_t             req;
    logic                ack_q;
    logic                in_range;
    logic                mem_we;
    logic [WB_DAT_W-1:0] mem_rdata;

    // Addresses beyond the RAM must not alias onto low words.
    assign in_range = (req.adr >> AW) == '0;

    // Write commits on the edge closing ACK, and only if the master still holds cyc.
    assign mem_we = (state == ACK) && req.we && bus__cyc && in_range;

    // The RAM reads the latched address every cycle, so the edge closing the
    // last WAIT cycle leaves the word ready for ACK.
    wb_resp_mem #(
        .DEPTH (DEPTH_WORDS),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .sel   (req.sel),
        .addr  (req.adr[AW-1:0]),
        .wdata (req.dat),
        .rdata (mem_rdata)
    );

    assign bus__ack   = ack_q;
    assign bus__dat_r = (ack_q && !req.we && in_range) ? mem_rdata : '0;

    // Request FSM: accept and latch, count wait states (stall-extendable up to the cap), ack once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            ack_q <= 1'b0;
            req   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ack_q <= 1'b0;
                    if (bus__cyc && bus__stb) begin
                        req   <= '{we: bus__we, adr: bus__adr, sel: bus__sel, dat: bus__dat_w};
                        cnt   <= 3'd1;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (!bus__cyc) begin
                        state <= IDLE;
                    end else if (cnt >= WS && (!stall_i || cnt == WB_CNT_MAX)) begin
                        state <= ACK;
                        ack_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                ACK: begin
                    ack_q <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    ack_q <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
